// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM encoding, reset PC,
// the nop word and the debug view of fetch state.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef struct packed {
        fetch_state_e state;
        logic         f_valid;
        logic         pend_redir;
    } fetch_dbg_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    // A request transfers on a rising edge where imem_req && imem_ready; the
    // master keeps imem_req/imem_addr stable until then. imem_rvalid is a
    // one-cycle pulse, at least one cycle after the transfer, with imem_rdata.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit_next_pc.sv
// Next fetch PC select: current redirect, then latched redirect, then pc+4,
// always word aligned.
module if_fetch_unit_next_pc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              pend_redir,
    input  logic [ADDR_W-1:0] pend_pc,
    output logic [ADDR_W-1:0] next_pc
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] raw_pc;

    always_comb begin
        raw_pc = pc + ADDR_W'(4);
        if (redirect_valid) begin
            raw_pc = redirect_pc;
        end else if (pend_redir) begin
            raw_pc = pend_pc;
        end
        next_pc = raw_pc & ALIGN_MASK;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request at a time, a
// one-word buffer feeding IF/ID, and MIPS delay-slot redirect handling.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    if_fetch_unit_if.master   imem,
    output logic [ADDR_W-1:0] F_PC,
    output logic [31:0]       F_Instr,
    output logic              fd_wren,
    output logic              fd_flush,
    output fetch_dbg_t        dbg
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_redir_q, pend_redir_d;
    logic              f_valid_q, f_valid_d;
    logic [ADDR_W-1:0] f_pc_q, f_pc_d;
    logic [31:0]       f_instr_q, f_instr_d;
    logic [ADDR_W-1:0] next_pc;
    logic              handoff;

    assign handoff = f_valid_q && !stall;

    if_fetch_unit_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc             (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pend_redir     (pend_redir_q),
        .pend_pc        (pend_pc_q),
        .next_pc        (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (imem.imem_ready)  state_d = S_WAIT;
            S_WAIT:  if (imem.imem_rvalid) state_d = S_HOLD;
            S_HOLD:  if (handoff)          state_d = S_REQ;
            default:                       state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state_q == S_REQ) && !reset;
        imem.imem_addr = pc_q & ALIGN_MASK;
        fd_wren        = handoff;
        fd_flush       = !f_valid_q && !stall;
    end

    // The buffered word is the delay slot of any redirect seen before its
    // handoff, so a redirect only steers the PC that follows the handoff.
    always_comb begin
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_redir_d = pend_redir_q;
        f_valid_d    = f_valid_q;
        f_pc_d       = f_pc_q;
        f_instr_d    = f_instr_q;
        if (state_q == S_WAIT && imem.imem_rvalid) begin
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
            f_instr_d = imem.imem_rdata;
        end
        if (handoff) begin
            f_valid_d    = 1'b0;
            pc_d         = next_pc;
            pend_redir_d = 1'b0;
        end else if (redirect_valid) begin
            pend_redir_d = 1'b1;
            pend_pc_d    = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_redir_q <= 1'b0;
            f_valid_q    <= 1'b0;
            f_pc_q       <= '0;
            f_instr_q    <= NOP_WORD;
        end else begin
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_redir_q <= pend_redir_d;
            f_valid_q    <= f_valid_d;
            f_pc_q       <= f_pc_d;
            f_instr_q    <= f_instr_d;
        end
    end

    assign F_PC           = f_pc_q;
    assign F_Instr        = f_instr_q;
    assign dbg.state      = state_q;
    assign dbg.f_valid    = f_valid_q;
    assign dbg.pend_redir = pend_redir_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: behavioural instruction memory, a
// scoreboard of expected request addresses and delivered words, and checks.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        fd_wren;
    logic        fd_flush;
    fetch_dbg_t  dbg;

    if_fetch_unit_if #(.ADDR_W(ADDR_W)) imem_bus ();

    if_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .F_PC           (F_PC),
        .F_Instr        (F_Instr),
        .fd_wren        (fd_wren),
        .fd_flush       (fd_flush),
        .dbg            (dbg)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int handoffs = 0;
    int rsp_lat  = 1;

    logic [63:0] exp_q[$];
    logic [31:0] exp_addr_q[$];

    // Memory contents: word at 0x3000 is 0xA, 0x3004 is 0xB, and so on.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) - 32'h0000_0C00 + 32'h0000_000A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input bit with_data);
        exp_addr_q.push_back(a);
        if (with_data) exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_handoffs(input int target, input int budget, input string tag);
        int n = 0;
        while (handoffs < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(handoffs >= target), 64'd1);
    endtask

    task automatic wait_state(input fetch_state_e s, input int budget, input string tag);
        int n = 0;
        while (dbg.state != s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(dbg.state), 64'(s));
    endtask

    task automatic wait_hold_pc(input logic [31:0] pc, input int budget, input string tag);
        int n = 0;
        while (!(dbg.f_valid && F_PC == pc) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(dbg.f_valid && F_PC == pc), 64'd1);
    endtask

    // Instruction memory: one request in flight, response rsp_lat cycles
    // after acceptance, garbage on rdata whenever rvalid is low.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] a;
        pend = 1'b0;
        cnt  = 0;
        a    = '0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_rdata  = $urandom;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_bus.imem_rvalid = 1'b1;
                        imem_bus.imem_rdata  = mem_word(a);
                        pend = 1'b0;
                    end
                end
                if (imem_bus.imem_req && imem_bus.imem_ready) begin
                    pend = 1'b1;
                    a    = imem_bus.imem_addr;
                    cnt  = rsp_lat;
                end
            end
        end
    end

    // Scoreboard and protocol monitor.
    initial begin
        logic        prev_wait;
        logic [31:0] prev_addr;
        logic [63:0] e;
        logic [31:0] ea;
        prev_wait = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) begin
                    check("req_held", 64'(imem_bus.imem_req), 64'd1);
                    check("addr_held", 64'(imem_bus.imem_addr), 64'(prev_addr));
                end
                if (stall) check("stall_ctl", 64'({fd_wren, fd_flush}), 64'd0);
                else       check("wren_xor_flush", 64'(fd_wren ^ fd_flush), 64'd1);
                if (fd_wren) begin
                    handoffs++;
                    check("handoff_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("F_PC", 64'(F_PC), 64'(e[63:32]));
                        check("F_Instr", 64'(F_Instr), 64'(e[31:0]));
                    end
                end
                if (imem_bus.imem_req && imem_bus.imem_ready) begin
                    check("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                    if (exp_addr_q.size() != 0) begin
                        ea = exp_addr_q.pop_front();
                        check("imem_addr", 64'(imem_bus.imem_addr), 64'(ea));
                    end
                end
                prev_wait = imem_bus.imem_req && !imem_bus.imem_ready;
                prev_addr = imem_bus.imem_addr;
            end
        end
    end

    initial begin
        reset               = 1'b1;
        stall               = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        imem_bus.imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_fetch(32'h3000 + 32'(4 * i), 1'b1);

        // Reset values
        tick();
        tick();
        @(negedge clk);
        check("rst_req", 64'(imem_bus.imem_req), 64'd0);
        check("rst_F_PC", 64'(F_PC), 64'd0);
        check("rst_F_Instr", 64'(F_Instr), 64'd0);
        check("rst_state", 64'(dbg.state), 64'(S_REQ));
        check("rst_f_valid", 64'(dbg.f_valid), 64'd0);
        check("rst_pend", 64'(dbg.pend_redir), 64'd0);
        tick();
        reset = 1'b0;

        // Memory not ready for 3 cycles: request held, bubbles to D
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_req", 64'(imem_bus.imem_req), 64'd1);
            check("wait_addr", 64'(imem_bus.imem_addr), 64'h3000);
            check("wait_flush", 64'(fd_flush), 64'd1);
            tick();
        end
        imem_bus.imem_ready = 1'b1;
        wait_handoffs(2, 40, "first_two_words");

        // Stall while 0x3008 is buffered
        stall = 1'b1;
        wait_hold_pc(32'h3008, 30, "hold_3008");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_wren", 64'(fd_wren), 64'd0);
            check("stall_flush", 64'(fd_flush), 64'd0);
            check("stall_F_Instr", 64'(F_Instr), 64'h0000_000C);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_wren", 64'(fd_wren), 64'd1);
        tick();

        // Redirect while 0x3010 is in flight: 0x3010 is the delay slot
        wait_handoffs(4, 30, "deliver_300c");
        rsp_lat = 3;
        wait_state(S_WAIT, 30, "inflight_3010");
        push_fetch(32'h3100, 1'b1);
        push_fetch(32'h3104, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        tick();
        redirect_valid = 1'b0;
        check("pend_set", 64'(dbg.pend_redir), 64'd1);
        wait_handoffs(6, 40, "deliver_3100");

        // Reset while a response is outstanding
        wait_state(S_WAIT, 30, "inflight_3104");
        reset = 1'b1;
        @(negedge clk);
        check("rst2_req", 64'(imem_bus.imem_req), 64'd0);
        tick();
        reset   = 1'b0;
        rsp_lat = 1;
        check("rst2_state", 64'(dbg.state), 64'(S_REQ));
        check("rst2_f_valid", 64'(dbg.f_valid), 64'd0);
        check("rst2_F_PC", 64'(F_PC), 64'd0);
        for (int i = 0; i < 9; i++) push_fetch(32'h3000 + 32'(4 * i), 1'b1);
        push_fetch(32'h3200, 1'b1);
        @(negedge clk);
        check("rst2_addr", 64'(imem_bus.imem_addr), 64'h3000);
        tick();

        // Redirect coincident with the handoff of 0x3020, unaligned target
        wait_handoffs(14, 80, "deliver_301c");
        stall = 1'b1;
        wait_hold_pc(32'h3020, 30, "hold_3020");
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3203;
        @(negedge clk);
        check("coinc_wren", 64'(fd_wren), 64'd1);
        tick();
        redirect_valid = 1'b0;
        check("coinc_pend_clear", 64'(dbg.pend_redir), 64'd0);
        check("coinc_state", 64'(dbg.state), 64'(S_REQ));
        wait_handoffs(16, 30, "deliver_3200");
        imem_bus.imem_ready = 1'b0;
        repeat (5) tick();

        check("data_drained", 64'(exp_q.size()), 64'd0);
        check("addr_drained", 64'(exp_addr_q.size()), 64'd0);
        check("handoff_total", 64'(handoffs), 64'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-stage producer for the IF/ID pipeline register.
- Holds the architectural PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Buffers the returned word and presents it as F_PC/F_Instr, together with the write-enable and flush controls the IF/ID register consumes.
- Honours ID-stage stalls and branch/jump redirects with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: ID stage must hold; IF/ID must not load
- redirect_valid  in  1  instruction in D is a taken branch/jump
- redirect_pc  in  ADDR_W  target of that branch/jump
- imem_req  out  1  request valid
- imem_addr  out  ADDR_W  word address; bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response word valid (at least 1 cycle after acceptance)
- imem_rdata  in  32  response word
- F_PC  out  ADDR_W  PC of buffered instruction
- F_Instr  out  32  buffered instruction
- fd_wren  out  1  IF/ID load enable
- fd_flush  out  1  IF/ID load bubble (nop, PC 0)

Behaviour:
- Reset: pc=RESET_PC; state=S_REQ; f_valid=0; pend_redir=0; F_PC=0; F_Instr=0; imem_req=0 during the reset cycle. The instruction memory shares the same reset, so in-flight responses are cancelled and none arrive after reset.
- S_REQ:
  - imem_req=1, imem_addr={pc[ADDR_W-1:2],2'b00}.
  - Request and address held stable until imem_ready=1, then go to S_WAIT.
- S_WAIT:
  - imem_req=0.
  - On imem_rvalid: F_Instr<=imem_rdata, F_PC<=pc, f_valid<=1, go to S_HOLD.
  - imem_rvalid in any other state is ignored.
- S_HOLD: buffer valid; wait for handoff.
- Handoff = f_valid && !stall, in the same cycle:
  - fd_wren=1, fd_flush=0.
  - f_valid<=0, pc<=next_pc, state<=S_REQ.
- Bubble = !f_valid && !stall: fd_wren=0, fd_flush=1, so D receives a nop while fetch is outstanding.
- Stall: fd_wren=0, fd_flush=0 regardless of f_valid. The buffer and outstanding request are unaffected.
- next_pc priority:
  1. redirect_valid this cycle: redirect_pc.
  2. pend_redir set: pend_pc.
  3. Otherwise pc+4.
  - Low two bits are forced to 0.
  - Arithmetic is modulo 2^ADDR_W: pc 32'hFFFF_FFFC + 4 = 0.
- Delay slot:
  - Whatever occupies the F slot when redirect_valid is seen (buffered or in flight) is the delay slot and is always delivered.
  - The redirect takes effect on the PC after that delivery.
- Redirect capture:
  - redirect_valid without handoff sets pend_redir<=1, pend_pc<=redirect_pc. A later redirect overwrites.
  - redirect_valid held across stall cycles re-captures the same value.
  - Any handoff clears pend_redir.
- Latency: with imem_ready=1 and rvalid one cycle after acceptance, one instruction every 3 cycles (REQ, WAIT, HOLD/handoff). Throughput is not a goal; correctness under arbitrary latency is.
- Outputs F_PC/F_Instr keep their last value after handoff until the next capture.

Decomposition:
- Shared package/def file: state encodings S_REQ/S_WAIT/S_HOLD, RESET_PC constant, NOP word 32'h0.
- One natural sub-module: if_next_pc (combinational next_pc select and alignment).
- FSM, buffer and redirect latch stay in if_fetch_unit.

Test Plan:
- Reset, imem_ready=1, rvalid 1 cycle later, words 0xA,0xB:
  - requests at 0x3000, 0x3004.
  - fd_wren pulses with F_PC=0x3000/F_Instr=0xA, then 0x3004/0xB.
  - fd_flush=1 in non-handoff, non-stall cycles.
- imem_ready low for 3 cycles at addr 0x3000 -> imem_req/imem_addr stable all 3 cycles; single acceptance; no duplicate request.
- Buffered word at 0x3008 with stall=1 for 4 cycles -> fd_wren=0, fd_flush=0 for 4 cycles; word delivered in the first cycle stall=0.
- redirect_valid=1, redirect_pc=0x3100 while request for 0x3010 is in flight:
  - 0x3010 is still delivered (delay slot).
  - Next request is 0x3100, not 0x3014.
- redirect_valid coincident with handoff of 0x3020, redirect_pc=0x3203 -> next imem_addr=0x3200; pend_redir not left set.
- reset asserted in S_WAIT -> next cycle pc=0x3000; f_valid=0; the first post-reset request is to 0x3000.
